// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, default
// parameters and the starvation-counter width helper.
package dmem_arb_pkg;

  localparam logic [1:0] ARB   = 2'd0;
  localparam logic [1:0] FORCE = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  localparam int ADDR_W_DEF     = 10;
  localparam int STARVE_MAX_DEF = 8;

  // Ceiling log2 with a floor of one bit, usable in constant expressions.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

  // Bits needed to hold 0..max inclusive.
  function automatic int cnt_width(input int max);
    return clog2(max + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around the arbiter: CPU MEM-stage side, debug/loader side and
// the data-memory side. The arbiter is the slave; the surrounding system is the master.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10
);

  logic              MEM_memread;
  logic              MEM_memwrite;
  logic [ADDR_W-1:0] MEM_addr;
  logic [31:0]       MEM_wdata;
  logic [31:0]       MEM_rdata;
  logic              mem_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_ack;
  logic [31:0]       dbg_rdata;

  logic [ADDR_W-1:0] dm_addr;
  logic              dm_we;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;

  modport slave (
    input  MEM_memread, MEM_memwrite, MEM_addr, MEM_wdata,
    output MEM_rdata, mem_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output dm_addr, dm_we, dm_wdata,
    input  dm_rdata
  );

  modport master (
    output MEM_memread, MEM_memwrite, MEM_addr, MEM_wdata,
    input  MEM_rdata, mem_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  dm_addr, dm_we, dm_wdata,
    output dm_rdata
  );

endinterface

// File: rtl/dmem_arbiter_starve_cnt.sv
// Saturating starvation counter: clear wins over increment, holds at MAX.
module arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter  int MAX = STARVE_MAX_DEF,
  localparam int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = (cnt == W'(MAX));

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a debug/loader port.
// Define DMEM_ARB_STARVE_EN to add the starvation counter and FORCE slot;
// without it the CPU has strict priority and never stalls.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hlt,
  dmem_arbiter_if.slave  bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be within 1..255");
  end

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              cpu_req;
  logic              dbg_elig;
  logic              cpu_win;
  logic              dbg_win;
  logic [ADDR_W-1:0] grant_addr;
  logic              dbg_ack_q;
  logic [31:0]       dbg_rdata_q;

  assign cpu_req  = bus.MEM_memread | bus.MEM_memwrite;
  // The ack cycle is never a grant cycle, which caps debug at one access per two cycles.
  assign dbg_elig = bus.dbg_req & ~dbg_ack_q;

  // Winner selection; nothing wins while reset is held.
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (!rst) begin
      case (state)
        HALT: dbg_win = dbg_elig;
`ifdef DMEM_ARB_STARVE_EN
        FORCE: begin
          dbg_win = dbg_elig;
          cpu_win = cpu_req & ~dbg_elig;
        end
`endif
        default: begin
          cpu_win = cpu_req;
          dbg_win = dbg_elig & ~cpu_req;
        end
      endcase
    end
  end

  assign grant_addr    = dbg_win ? bus.dbg_addr : bus.MEM_addr;
  assign bus.dm_addr   = grant_addr;
  assign bus.dm_we     = dbg_win ? bus.dbg_we : (cpu_win & bus.MEM_memwrite);
  assign bus.dm_wdata  = dbg_win ? bus.dbg_wdata : bus.MEM_wdata;
  assign bus.MEM_rdata = bus.dm_rdata;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CNT_W = cnt_width(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_sat;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             starve_hit;

  assign cnt_inc = (state == ARB) & dbg_elig & cpu_win;
  assign cnt_clr = dbg_win | ~bus.dbg_req;
  // True when the counter will sit at STARVE_MAX after this edge.
  assign starve_hit = ~cnt_clr &
                      (starve_sat | (cnt_inc & (starve_cnt == CNT_W'(STARVE_MAX - 1))));

  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (cnt_clr),
    .cnt (starve_cnt),
    .sat (starve_sat)
  );

  assign bus.mem_stall = cpu_req & dbg_win & (state != HALT);
`else
  assign bus.mem_stall = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (hlt) begin
      state_nxt = HALT;
    end else begin
      case (state)
`ifdef DMEM_ARB_STARVE_EN
        ARB:   if (starve_hit) state_nxt = FORCE;
        FORCE: if (dbg_win || !bus.dbg_req) state_nxt = ARB;
`endif
        default: state_nxt = ARB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state     <= state_nxt;
      dbg_ack_q <= dbg_win;
      if (dbg_win && !bus.dbg_we) dbg_rdata_q <= bus.dm_rdata;
    end
  end

  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a per-cycle behavioural model plus
// directed scenarios with literal expectations.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 10;
  localparam int SM = 8;

  logic clk = 1'b0;
  logic rst;
  logic hlt;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW)) bus ();

  dmem_arbiter #(
    .ADDR_W     (AW),
    .STARVE_MAX (SM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hlt (hlt),
    .bus (bus)
  );

  // Environment memory: combinational read, write on the clock edge.
  logic [31:0] mem [1024];
  assign bus.dm_rdata = mem[bus.dm_addr];
  always @(posedge clk) if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who should own the port this cycle, from the rules alone.
  logic [31:0] ref_mem [1024];
  bit          m_halt;
  bit          m_ack;
  logic [31:0] m_rdata;
  int          m_wait;

  always @(negedge clk) begin : model
    bit          elig, cpu, cw, dw, e_we, e_stall;
    logic [AW-1:0] e_addr;
    logic [31:0] e_wd;
    if (rst) begin
      check("rst dm_we", 32'(bus.dm_we), 32'd0);
      check("rst mem_stall", 32'(bus.mem_stall), 32'd0);
      check("rst dbg_ack", 32'(bus.dbg_ack), 32'd0);
      check("rst dbg_rdata", bus.dbg_rdata, 32'd0);
      m_halt = 1'b0; m_ack = 1'b0; m_rdata = '0; m_wait = 0;
    end else begin
      elig = bus.dbg_req && !m_ack;
      cpu  = bus.MEM_memread || bus.MEM_memwrite;
      if (m_halt) begin
        dw = elig; cw = 1'b0;
      end else begin
`ifdef DMEM_ARB_STARVE_EN
        if (m_wait >= SM) begin
          dw = elig; cw = cpu && !dw;
        end else begin
          cw = cpu; dw = elig && !cpu;
        end
`else
        cw = cpu; dw = elig && !cpu;
`endif
      end
      e_we    = dw ? bus.dbg_we : (cw && bus.MEM_memwrite);
      e_addr  = dw ? bus.dbg_addr : bus.MEM_addr;
      e_wd    = dw ? bus.dbg_wdata : bus.MEM_wdata;
      e_stall = cpu && dw && !m_halt;

      check("mem_stall", 32'(bus.mem_stall), 32'(e_stall));
      check("dm_we", 32'(bus.dm_we), 32'(e_we));
      check("dm_addr", 32'(bus.dm_addr), 32'(e_addr));
      check("dbg_ack", 32'(bus.dbg_ack), 32'(m_ack));
      check("dbg_rdata", bus.dbg_rdata, m_rdata);
      if (e_we) check("dm_wdata", bus.dm_wdata, e_wd);
      if (cw && bus.MEM_memread) check("MEM_rdata", bus.MEM_rdata, ref_mem[bus.MEM_addr]);

      if (dw && !bus.dbg_we) m_rdata = ref_mem[bus.dbg_addr];
      if (e_we) ref_mem[e_addr] = e_wd;
      m_ack = dw;
      if (dw || !bus.dbg_req) m_wait = 0;
      else if (!m_halt && elig && cw && m_wait < SM) m_wait++;
      m_halt = hlt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [31:0] d);
    bus.MEM_memread  = rd;
    bus.MEM_memwrite = wr;
    bus.MEM_addr     = a;
    bus.MEM_wdata    = d;
  endtask

  task automatic dbg_drive(input bit req, input bit we, input logic [AW-1:0] a, input logic [31:0] d);
    bus.dbg_req   = req;
    bus.dbg_we    = we;
    bus.dbg_addr  = a;
    bus.dbg_wdata = d;
  endtask

  // Cycles from driving a request until dbg_ack is seen; 20 means it never came.
  task automatic wait_ack(output int n);
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (bus.dbg_ack) break;
    end
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int stall_cyc, ack_cyc, busy;
    logic [31:0] ld_at_ack;
    bit stall_at_ack;

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA5A5_0000 | 32'(i);
      ref_mem[i] = 32'hA5A5_0000 | 32'(i);
    end
    rst = 1'b1;
    hlt = 1'b0;
    cpu_drive(1'b0, 1'b0, '0, '0);
    dbg_drive(1'b0, 1'b0, '0, '0);
    #1;
    check("init dbg_ack", 32'(bus.dbg_ack), 32'd0);
    check("init dbg_rdata", bus.dbg_rdata, 32'd0);
    check("init dm_we", 32'(bus.dm_we), 32'd0);
    repeat (2) step();
    rst = 1'b0;

    // CPU store then load at 0x010.
    cpu_drive(1'b0, 1'b1, 10'h010, 32'hDEAD_BEEF);
    step();
    cpu_drive(1'b1, 1'b0, 10'h010, '0);
    #1;
    check("cpu load data", bus.MEM_rdata, 32'hDEAD_BEEF);
    check("cpu load stall", 32'(bus.mem_stall), 32'd0);
    step();
    cpu_drive(1'b0, 1'b0, '0, '0);

    // Idle-CPU debug write then read at 0x020.
    dbg_drive(1'b1, 1'b1, 10'h020, 32'h1234_5678);
    wait_ack(n);
    check("dbg write ack latency", 32'(n), 32'd1);
    dbg_drive(1'b0, 1'b0, '0, '0);
    step();
    dbg_drive(1'b1, 1'b0, 10'h020, '0);
    wait_ack(n);
    check("dbg read ack latency", 32'(n), 32'd1);
    check("dbg read data", bus.dbg_rdata, 32'h1234_5678);
    dbg_drive(1'b0, 1'b0, '0, '0);
    step();

    // Reset while a debug read ack is pending.
    dbg_drive(1'b1, 1'b0, 10'h010, '0);
    step();
    check("pre-reset ack", 32'(bus.dbg_ack), 32'd1);
    check("pre-reset rdata", bus.dbg_rdata, 32'hDEAD_BEEF);
    rst = 1'b1;
    dbg_drive(1'b0, 1'b0, '0, '0);
    #1;
    check("reset drops ack", 32'(bus.dbg_ack), 32'd0);
    check("reset clears rdata", bus.dbg_rdata, 32'd0);
    check("reset dm_we", 32'(bus.dm_we), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    #1;
    check("post-reset dm_we", 32'(bus.dm_we), 32'd0);
    step();

    // Continuous CPU loads with a held debug read of 0x020.
`ifdef DMEM_ARB_STARVE_EN
    busy = 30;
`else
    busy = 12;
`endif
    stall_cyc = 0; ack_cyc = 0; ld_at_ack = '0; stall_at_ack = 1'b1;
    cpu_drive(1'b1, 1'b0, 10'h010, '0);
    dbg_drive(1'b1, 1'b0, 10'h020, '0);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (bus.mem_stall && stall_cyc == 0) stall_cyc = cyc;
      if (bus.dbg_ack && ack_cyc == 0) begin
        ack_cyc      = cyc;
        ld_at_ack    = bus.MEM_rdata;
        stall_at_ack = bus.mem_stall;
      end
      if (ack_cyc != 0) break;
      @(posedge clk);
      #1;
      if (bus.dbg_ack) dbg_drive(1'b0, 1'b0, '0, '0);
      if (cyc >= busy) cpu_drive(1'b0, 1'b0, '0, '0);
    end
`ifdef DMEM_ARB_STARVE_EN
    check("starve stall cycle", 32'(stall_cyc), 32'd9);
    check("starve ack cycle", 32'(ack_cyc), 32'd10);
    check("stalled load data", ld_at_ack, 32'hDEAD_BEEF);
    check("stalled load no stall", 32'(stall_at_ack), 32'd0);
`else
    check("strict stall cycle", 32'(stall_cyc), 32'd0);
    check("strict ack cycle", 32'(ack_cyc), 32'd14);
`endif
    check("starve read data", bus.dbg_rdata, 32'h1234_5678);
    step();
    cpu_drive(1'b0, 1'b0, '0, '0);
    dbg_drive(1'b0, 1'b0, '0, '0);
    step();

    // Halt with a stuck CPU store: debug owns the port, no stall.
    cpu_drive(1'b0, 1'b1, 10'h3FF, 32'hCAFE_F00D);
    hlt = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      dbg_drive(1'b1, 1'b0, AW'(k), '0);
      #1;
      check("halt stall", 32'(bus.mem_stall), 32'd0);
      wait_ack(n);
      check("halt ack latency", 32'(n), 32'd1);
      check("halt read data", bus.dbg_rdata, 32'hA5A5_0000 + 32'(k));
      dbg_drive(1'b0, 1'b0, '0, '0);
      #1;
      check("halt cpu store ignored", 32'(bus.dm_we), 32'd0);
      step();
    end

    rst = 1'b1;
    hlt = 1'b0;
    cpu_drive(1'b0, 1'b0, '0, '0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port between the pipeline MEM stage and an external debug/loader port. It sits between the EX/MEM buffer outputs and the data memory, feeding read data into the MEM/WB buffer. The CPU normally has priority. A starvation counter bounds debug latency, and a halted pipeline hands the port entirely to debug. When the CPU loses the port it receives a stall.

## Interface
Parameters:
- ADDR_W, 10, word-address width
- STARVE_MAX, 8, consecutive denied debug cycles before a forced debug slot (1..255)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- hlt  in  1  pipeline halted (WB-stage halt flag)
- MEM_memread  in  1  CPU load request
- MEM_memwrite  in  1  CPU store request
- MEM_addr  in  ADDR_W  CPU word address
- MEM_wdata  in  32  CPU store data
- MEM_rdata  out  32  CPU load data, combinational from memory
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB
- dbg_req  in  1  debug request, held until dbg_ack
- dbg_we  in  1  debug write (1) / read (0)
- dbg_addr  in  ADDR_W  debug word address
- dbg_wdata  in  32  debug write data
- dbg_ack  out  1  one-cycle completion pulse, registered
- dbg_rdata  out  32  debug read data, valid with dbg_ack, registered
- dm_addr  out  ADDR_W  memory address
- dm_we  out  1  memory write enable (write on clock edge)
- dm_wdata  out  32  memory write data
- dm_rdata  in  32  memory combinational read data

## Operation
- cpu_req = MEM_memread | MEM_memwrite. Debug is eligible when dbg_req=1 and dbg_ack=0 this cycle.
- FSM states:
  - ARB: the CPU wins if cpu_req; otherwise debug wins if eligible.
  - FORCE: debug wins if eligible. Any cpu_req is stalled.
  - HALT: debug wins if eligible. CPU requests are ignored and mem_stall=0.
- FSM transitions:
  - ARB -> FORCE when starve_cnt reaches STARVE_MAX at a clock edge.
  - FORCE -> ARB after one debug grant, or immediately if dbg_req drops.
  - Any state -> HALT when hlt=1.
  - HALT -> ARB when hlt=0 (reset only in practice).
- starve_cnt:
  - Increments in ARB when debug is eligible but the CPU wins.
  - Clears on any debug grant or when dbg_req=0.
  - Saturates at STARVE_MAX.
- Grant mux, combinational:
  - dm_addr, dm_we and dm_wdata follow the winner.
  - dm_we = winner's write flag.
  - With no winner, dm_we=0 and dm_addr=MEM_addr.
- mem_stall = cpu_req & debug wins & not HALT.
- A stalled CPU request repeats unchanged next cycle because the pipeline is frozen. No CPU request is ever lost.
- On a debug grant, next edge: dbg_ack<=1; dbg_rdata<=dm_rdata for reads, unchanged for writes.
- Debug requester must drop or change its request in the ack cycle. The arbiter never grants debug in a cycle where dbg_ack=1.

## Timing
- CPU access: zero added latency when it wins. Read data is combinational in the same cycle; the write lands at the cycle-end edge.
- Debug access: grant in cycle N, dbg_ack/dbg_rdata in cycle N+1.
- Back-to-back debug throughput: at most one access every 2 cycles.
- Worst-case debug latency with continuous CPU traffic: STARVE_MAX + 1 cycles to grant.
- Reset values: state=ARB, starve_cnt=0, dbg_ack=0, dbg_rdata=0.
- While rst=1 the combinational outputs are dm_we=0 and mem_stall=0.
- Reset mid-access: any pending debug ack is dropped and the requester re-issues. A write in flight at the reset edge is not guaranteed.
- Simultaneous CPU and debug access to the same address: only one is granted per cycle, so there is no collision.

## Configuration
- DMEM_ARB_STARVE_EN defined: starvation counter and FORCE state are present, as described above.
- DMEM_ARB_STARVE_EN undefined: the arbiter uses strict CPU priority.
  - FORCE and starve_cnt are removed.
  - mem_stall is constant 0.
  - Debug is served only on CPU-idle cycles or in HALT.

## Structure
- Shared package dmem_arb_pkg holds:
  - state encodings ARB=2'd0, FORCE=2'd1, HALT=2'd2
  - the default STARVE_MAX
  - the counter-width function clog2(STARVE_MAX+1)
- One natural sub-module, arb_starve_cnt: saturating counter with inc/clr/sat, instantiated only under DMEM_ARB_STARVE_EN.

## Test plan
- Reset: assert rst mid-debug-read -> dbg_ack=0, dbg_rdata=0 and state ARB immediately; after release, dm_we=0 with no requests.
- CPU-only: store 0xDEADBEEF to 0x010, then load 0x010 -> MEM_rdata=0xDEADBEEF in the load cycle; mem_stall=0 throughout.
- Idle debug: CPU idle, debug write 0x12345678 to 0x020, then debug read 0x020 -> dbg_ack one cycle after each grant; read returns 0x12345678.
- Starvation (STARVE_MAX=8, macro on): CPU loads every cycle with dbg_req held -> debug granted on cycle 9 with mem_stall=1 that cycle; the stalled CPU load completes on cycle 10 with correct data.
- Macro off, same stimulus -> dbg_ack never asserts while CPU traffic continues; the grant occurs on the first CPU-idle cycle.
- Halt: assert hlt with cpu_req stuck high -> mem_stall=0; debug reads at 0x000..0x003 each ack within 1 cycle of grant.
